// File: rtl/load_store_unit.sv
// Load/store unit: one req/ack data-bus transaction per accepted request, with
// sign/zero-extended load writeback. Optional bus timeout under `LSU_TIMEOUT_EN.
module load_store_unit #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        memr_ie,
  input  logic        memw_ie,
  input  logic [2:0]  funct3_ie,
  input  logic [31:0] addr_ie,
  input  logic [31:0] wdata_ie,
  input  logic [4:0]  rd_ie,
  input  logic        fw_ie,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output logic        mem_stall,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic        wb_fw,
  output logic [31:0] wb_data,
  output logic        misalign,
  output logic        timeout_err,
  output logic [1:0]  state_dbg
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] WB   = 2'd2;

  if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
    $error("TIMEOUT must be in 1..255");
  end

  logic [1:0]  state;
  logic        req_any, is_store, aligned, accept;
  logic [3:0]  be_next;
  logic [31:0] wdata_next;
  logic        we_r, fw_r;
  logic [2:0]  f3_r;
  logic [1:0]  off_r;
  logic [29:0] addr_r;
  logic [4:0]  rd_r;
  logic [3:0]  be_r;
  logic [31:0] wdata_r;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic [31:0] ld_ext;

  assign state_dbg = state;

  always_comb begin
    req_any  = memr_ie | memw_ie;
    is_store = memw_ie & ~memr_ie;
    case (funct3_ie[1:0])
      2'b00:   aligned = 1'b1;
      2'b01:   aligned = ~addr_ie[0];
      default: aligned = (addr_ie[1:0] == 2'b00);
    endcase
    accept     = ~rst & (state == IDLE) & req_any & aligned;
    be_next    = 4'b1111;
    wdata_next = wdata_ie;
    if (is_store) begin
      case (funct3_ie[1:0])
        2'b00: begin
          be_next    = 4'b0001 << addr_ie[1:0];
          wdata_next = {4{wdata_ie[7:0]}};
        end
        2'b01: begin
          be_next    = addr_ie[1] ? 4'b1100 : 4'b0011;
          wdata_next = {2{wdata_ie[15:0]}};
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    lane_b = bus_rdata[{off_r, 3'b000} +: 8];
    lane_h = bus_rdata[{off_r[1], 4'b0000} +: 16];
    case (f3_r)
      3'b000:  ld_ext = {{24{lane_b[7]}}, lane_b};
      3'b001:  ld_ext = {{16{lane_h[15]}}, lane_h};
      3'b100:  ld_ext = {24'h0, lane_b};
      3'b101:  ld_ext = {16'h0, lane_h};
      default: ld_ext = bus_rdata;
    endcase
  end

  // Bus handshake: bus_req rises the cycle after acceptance and holds, with
  // addr/we/be/wdata stable, through the cycle in which bus_ack is sampled high.
  // bus_ack outside REQ is ignored. All bus outputs read zero when not in REQ.
  assign bus_req   = (state == REQ);
  assign bus_we    = bus_req & we_r;
  assign bus_addr  = bus_req ? {addr_r, 2'b00} : 32'h0;
  assign bus_be    = bus_req ? be_r : 4'h0;
  assign bus_wdata = bus_req ? wdata_r : 32'h0;
  assign mem_stall = accept | (state == REQ);

`ifdef LSU_TIMEOUT_EN
  logic [7:0] wait_cnt;
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);
`else
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      we_r     <= 1'b0;
      fw_r     <= 1'b0;
      f3_r     <= 3'b000;
      off_r    <= 2'b00;
      addr_r   <= 30'h0;
      rd_r     <= 5'd0;
      be_r     <= 4'h0;
      wdata_r  <= 32'h0;
      wb_valid <= 1'b0;
      wb_rd    <= 5'd0;
      wb_fw    <= 1'b0;
      wb_data  <= 32'h0;
      misalign <= 1'b0;
`ifdef LSU_TIMEOUT_EN
      wait_cnt    <= 8'd0;
      timeout_err <= 1'b0;
`endif
    end else begin
      misalign <= (state == IDLE) & req_any & ~aligned;
      wb_valid <= 1'b0;
`ifdef LSU_TIMEOUT_EN
      timeout_err <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (accept) begin
            state   <= REQ;
            we_r    <= is_store;
            fw_r    <= fw_ie;
            f3_r    <= funct3_ie;
            off_r   <= addr_ie[1:0];
            addr_r  <= addr_ie[31:2];
            rd_r    <= rd_ie;
            be_r    <= be_next;
            wdata_r <= wdata_next;
`ifdef LSU_TIMEOUT_EN
            wait_cnt <= 8'd0;
`endif
          end
        end
        REQ: begin
          if (bus_ack) begin
            if (we_r) begin
              state <= IDLE;
            end else begin
              state    <= WB;
              wb_data  <= ld_ext;
              wb_rd    <= rd_r;
              wb_fw    <= fw_r;
              // x0 is never written; f0 is a real register
              wb_valid <= (rd_r != 5'd0) | fw_r;
            end
          end
`ifdef LSU_TIMEOUT_EN
          else if (wait_cnt == TIMEOUT_LAST) begin
            state       <= IDLE;
            timeout_err <= 1'b1;
            wait_cnt    <= 8'd0;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
`endif
        end
        WB:      state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Data-memory access unit at the execute/memory boundary of the RISC-V core: accepts load/store requests from the IE stage, runs a req/ack transaction on the data bus, and returns sign/zero-extended load data to the integer or float register file. It drives the memory-side pipeline freeze (`mem_stall`) for the full duration of every bus access. Load-use hazard detection in ID works independently of this block, which delivers the actual load result.

## Interface
- `TIMEOUT`, 255: max `REQ` cycles without `bus_ack` before abort (used only with `LSU_TIMEOUT_EN`); 8-bit counter, range 1–255.
- `clk` in 1: core clock; all state on rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `memr_ie` in 1: load request from IE stage.
- `memw_ie` in 1: store request from IE stage.
- `funct3_ie` in 3: access type: LB 000, LH 001, LW 010, LBU 100, LHU 101; stores SB 000, SH 001, SW 010.
- `addr_ie` in 32: effective byte address.
- `wdata_ie` in 32: store data (rs2).
- `rd_ie` in 5: load destination register.
- `fw_ie` in 1: destination is float register file (FLW).
- `bus_req` out 1: bus request, held until ack.
- `bus_we` out 1: 1 = write.
- `bus_addr` out 32: word-aligned address (`addr[31:2],2'b00`).
- `bus_be` out 4: byte enables.
- `bus_wdata` out 32: lane-replicated store data.
- `bus_ack` in 1: transaction complete; `bus_rdata` valid when read.
- `bus_rdata` in 32: read data.
- `mem_stall` out 1: freeze PC/IF/ID/IE registers.
- `wb_valid` out 1: one-cycle load-result strobe.
- `wb_rd` out 5; `wb_fw` out 1; `wb_data` out 32: load result.
- `misalign` out 1: one-cycle misaligned-access flag.
- `timeout_err` out 1: one-cycle bus-timeout flag.

## Operation
- FSM states: `IDLE`, `REQ`, `WB`.
- IDLE accept: `memr_ie | memw_ie`. Both high → treated as load. Access captures `funct3`, `addr[1:0]`, `rd`, `fw`, op.
- Alignment: halfword requires `addr[0]=0`; word requires `addr[1:0]=0`. If misaligned: no bus access, `misalign` pulses next cycle, state stays `IDLE`, no `wb_valid`.
- `REQ`: `bus_req=1`; `bus_addr`, `bus_we`, `bus_be` and `bus_wdata` stay stable until ack.
- Ack on a load: register extended data, go to `WB`. Ack on a store: go to `IDLE`.
- `WB`: `wb_valid=1` for one cycle, then `IDLE`. Writeback is suppressed (`wb_valid=0`) when `rd=0` and `fw=0` (x0). f0 writes normally.
- Byte enables:
  - SB: `1<<addr[1:0]`, byte replicated ×4.
  - SH: `0011` or `1100` per `addr[1]`, half replicated ×2.
  - SW: `1111`.
  - Loads drive `1111`.
- Extension: select lane by `addr[1:0]`. LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
- `mem_stall` = accepted-aligned-request this cycle (combinational) OR `state==REQ`. It is low in `WB`, so the instruction in IE advances exactly as the result is written.
- Reset (any time, including mid-`REQ`): state → `IDLE`, counter cleared. All outputs 0 immediately: `bus_req`, `bus_we`, `bus_be`, `bus_addr`, `bus_wdata`, `mem_stall`, `wb_*`, `misalign`, `timeout_err`. A `bus_ack` arriving after reset is ignored.
- `bus_ack` while not in `REQ` is ignored.

## Timing
- Cycle 0: request accepted, `mem_stall=1`.
- Cycle 1: `bus_req=1`. The earliest ack is sampled at the end of cycle 1.
- Minimum load: result `wb_valid` in cycle 2; store complete in 2 cycles (stall cycles 0–1).
- Each cycle of ack delay adds one cycle to `REQ` and to the stall.
- `wb_data`, `wb_rd` and `wb_fw` are registered and valid only while `wb_valid=1`.
- Back-to-back: a new request may be accepted in the cycle after `WB` or after store completion.

## Configuration
- `LSU_TIMEOUT_EN` defined: an 8-bit counter increments each `REQ` cycle without ack. On reaching `TIMEOUT`:
  - `bus_req` drops.
  - `timeout_err` pulses one cycle.
  - Loads skip `WB` (no `wb_valid`).
  - State → `IDLE`, `mem_stall` releases.
  - Ack on the same edge as expiry wins.
- Not defined: `REQ` waits indefinitely; `timeout_err` tied 0; no counter logic.

## Test plan
- LB `addr=0x1003`, ack after 2 wait cycles, `rdata=0x80FF_FF00` → `bus_be=1111`, `bus_addr=0x1000`, `wb_data=0xFFFF_FF80`, `wb_valid` in cycle 4, `mem_stall` high cycles 0–3.
- SH `addr=0x2002`, `wdata=0x1234_ABCD`, immediate ack → `bus_we=1`, `bus_be=1100`, `bus_wdata=0xABCD_ABCD`, no `wb_valid`, stall cycles 0–1.
- LW `addr=0x0006` → `misalign` pulses in cycle 1, `bus_req` never asserts, `mem_stall` stays 0.
- FLW `rd=0`, `fw=1`, `rdata=0x3F80_0000` → `wb_valid=1`, `wb_fw=1`, `wb_rd=0`. Same access with `fw=0` → `wb_valid` stays 0.
- `rst` pulsed during the 3rd `REQ` cycle of an LHU → `bus_req` and `mem_stall` drop asynchronously; a late ack produces no `wb_valid`.
- With `LSU_TIMEOUT_EN`, `TIMEOUT=4`, no ack → `timeout_err` pulses after 4 `REQ` cycles, then a fresh LW with immediate ack completes normally.
